display_arbiter: RTL and testbench

DISPLAY_ARBITER -- requirements
Module: display_arbiter

---
 rtl/display_pkg.sv | 17 +
 rtl/rr_pick.sv | 31 +++
 rtl/display_arbiter.sv | 121 ++++++++++++
 tb/tb_display_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and sizing for the display arbiter.
package display_pkg;

  localparam int unsigned DIG_W    = 32;
  localparam int unsigned NREQ_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  // Index width for n requesters, at least one bit so NREQ=1 still elaborates.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick
  import display_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  localparam int unsigned IW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [NREQ-1:0] rot;
  logic [IW-1:0]   off;
  logic [IW:0]     sum;

  // Rotate requests so ptr_i sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot = NREQ'({req_i, req_i} >> ptr_i);
    off = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = (IW+1)'(ptr_i) + (IW+1)'(off);
    if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
    idx_o = IW'(sum);
    any_o = |req_i;
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one 8-digit display among NREQ requesters with a dwell timer.
module display_arbiter
  import display_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned HOLD = 100_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DIG_W-1:0]   data,
  input  logic                    freeze,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [DIG_W-1:0]        dig,
  output logic [idx_w(NREQ)-1:0]  owner,
  output logic                    busy
);

  localparam int unsigned OW = idx_w(NREQ);
  localparam int unsigned TW = 32;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DIG_W-1:0]  dig_q, dig_d;
  logic              busy_q, busy_d;
  logic [OW-1:0]     pick_idx;
  logic              pick_any;
  logic              expire;
  logic              rearb;
  logic [DIG_W-1:0]  data_a [NREQ];

  // Unpack the flat data bus into per-requester words.
  for (genvar g = 0; g < int'(NREQ); g++) begin : g_unpack
    assign data_a[g] = data[g*DIG_W +: DIG_W];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Next-state: dwell/expiry handling and re-arbitration; done is a same-cycle expiry strobe.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    dig_d   = dig_q;
    busy_d  = busy_q;
    expire  = 1'b0;
    rearb   = 1'b0;
    done    = '0;

    case (state_q)
      IDLE: rearb = 1'b1;
      SHOW: begin
        expire = !freeze && (timer_q == TW'(HOLD - 1));
        if (expire || !req[owner_q]) begin
          rearb = 1'b1;
        end else begin
          if (!freeze) timer_d = timer_q + TW'(1);
          dig_d = data_a[owner_q];
        end
      end
      default: rearb = 1'b1;
    endcase

    if (expire) done = gnt_q;

    if (rearb) begin
      timer_d = '0;
      if (pick_any) begin
        state_d = SHOW;
        gnt_d   = NREQ'(1) << pick_idx;
        owner_d = pick_idx;
        ptr_d   = (pick_idx == OW'(NREQ - 1)) ? '0 : pick_idx + OW'(1);
        dig_d   = data_a[pick_idx];
        busy_d  = 1'b1;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        owner_d = '0;
        busy_d  = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
      dig_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      dig_q   <= dig_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign dig   = dig_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Randomized and directed bench for display_arbiter against a rule-level reference model.
module tb_display_arbiter;

  localparam int NREQ = 4;
  localparam int HOLD = 4;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req;
  logic [127:0]  data;
  logic          freeze;
  logic [3:0]    gnt;
  logic [3:0]    done;
  logic [31:0]   dig;
  logic [1:0]    owner;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: who holds the display, where the next search starts, dwell count.
  bit          m_busy;
  int          m_owner;
  int          m_start;
  int          m_timer;
  logic [31:0] m_dig;
  logic [3:0]  done_seen;

  display_arbiter #(.NREQ(NREQ), .HOLD(HOLD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .data   (data),
    .freeze (freeze),
    .gnt    (gnt),
    .done   (done),
    .dig    (dig),
    .owner  (owner),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_start = 0;
    m_timer = 0;
    m_dig   = 32'h0;
  endtask

  task automatic check_regs();
    logic [3:0] eg;
    eg = m_busy ? 4'(1 << m_owner) : 4'h0;
    check("gnt", 32'(gnt), 32'(eg));
    check("owner", 32'(owner), 32'(m_owner));
    check("busy", 32'(busy), 32'(m_busy));
    check("dig", dig, m_dig);
    check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
  endtask

  // One clock: apply inputs, check the expiry strobe, advance model, check registers.
  task automatic cycle(input logic [3:0] r, input logic [127:0] d, input logic f);
    bit         expired;
    bit         found;
    logic [3:0] ed;
    req = r; data = d; freeze = f;
    #1;
    expired = m_busy && !f && (m_timer == HOLD - 1);
    ed = expired ? 4'(1 << m_owner) : 4'h0;
    done_seen = done;
    check("done", 32'(done), 32'(ed));
    check("done_in_gnt", 32'(done & ~gnt), 32'h0);
    if (!m_busy || expired || !r[m_owner]) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_start + k) % NREQ;
        if (!found && r[c]) begin
          found = 1;
          m_owner = c;
        end
      end
      m_timer = 0;
      if (found) begin
        m_busy  = 1;
        m_start = (m_owner + 1) % NREQ;
        m_dig   = d[32*m_owner +: 32];
      end else begin
        m_busy  = 0;
        m_owner = 0;
      end
    end else begin
      if (!f) m_timer++;
      m_dig = d[32*m_owner +: 32];
    end
    @(posedge clk);
    @(negedge clk);
    check_regs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; freeze = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_dig", dig, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_regs();
  endtask

  initial begin
    logic [127:0] d;
    logic [3:0]   r, prev;
    int           order[$];
    int           ndone;
    int           n;
    rst_n = 1'b0; req = '0; data = '0; freeze = 1'b0;
    model_reset();
    #12;
    @(negedge clk);
    do_reset();

    // Single requester: grant, live data, expiry on the 4th dwell cycle, re-grant.
    d = rnd_data(); d[31:0] = 32'h1234_5678;
    cycle(4'b0001, d, 1'b0);
    check("first_gnt", 32'(gnt), 32'h1);
    check("first_dig", dig, 32'h1234_5678);
    for (int i = 1; i <= 4; i++) cycle(4'b0001, rnd_data(), 1'b0);
    check("single_done", 32'(done_seen), 32'h1);
    check("single_regrant", 32'(gnt), 32'h1);

    // Rotation over 0,1,3 with one done per hand-over.
    do_reset();
    order.delete(); ndone = 0; prev = 4'h0;
    for (int i = 0; i < 17; i++) begin
      cycle(4'b1011, rnd_data(), 1'b0);
      if (done_seen != 4'h0) ndone++;
      if (gnt != prev) order.push_back(int'(owner));
      prev = gnt;
    end
    check("rr_len", 32'(order.size()), 32'd5);
    if (order.size() >= 4) begin
      check("rr_0", 32'(order[0]), 32'd0);
      check("rr_1", 32'(order[1]), 32'd1);
      check("rr_2", 32'(order[2]), 32'd3);
      check("rr_3", 32'(order[3]), 32'd0);
    end
    check("rr_dones", 32'(ndone), 32'd4);

    // Owner drop mid-dwell moves grant without done.
    do_reset();
    cycle(4'b0010, rnd_data(), 1'b0);
    cycle(4'b1010, rnd_data(), 1'b0);
    cycle(4'b1000, rnd_data(), 1'b0);
    check("drop_nodone", 32'(done_seen), 32'h0);
    check("drop_gnt", 32'(gnt), 32'h8);
    for (int i = 0; i < 4; i++) cycle(4'b1000, rnd_data(), 1'b0);
    check("drop_timer_restart", 32'(done_seen), 32'h8);

    // Freeze for 10 cycles stretches the dwell by exactly 10.
    do_reset();
    cycle(4'b0001, rnd_data(), 1'b0);
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle(4'b0001, rnd_data(), (i >= 2 && i <= 11));
      if (done_seen[0]) begin
        n = i;
        break;
      end
    end
    check("freeze_delay", 32'(n), 32'(HOLD + 10));

    // Reset mid-dwell of owner 2, then arbitration restarts at index 0.
    do_reset();
    cycle(4'b0100, rnd_data(), 1'b0);
    cycle(4'b0100, rnd_data(), 1'b0);
    do_reset();
    cycle(4'b0110, rnd_data(), 1'b0);
    check("post_rst_gnt", 32'(gnt), 32'h2);

    // Owner drop coincident with expiry counts as expiry.
    do_reset();
    cycle(4'b0001, rnd_data(), 1'b0);
    for (int i = 1; i <= 3; i++) cycle(4'b0011, rnd_data(), 1'b0);
    cycle(4'b0010, rnd_data(), 1'b0);
    check("coinc_done", 32'(done_seen), 32'h1);
    check("coinc_gnt", 32'(gnt), 32'h2);

    // Random traffic with sticky requests, sporadic freeze and resets.
    r = 4'($urandom());
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom());
      if ($urandom_range(0, 149) == 0) do_reset();
      cycle(r, rnd_data(), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
